// File: rtl/jump_branch_unit.sv
// Decode-stage jump/branch resolver for the 32-bit DLX pipeline: redirect decision, target and r31 link flop.
// Optional FP branches (BFPT/BFPF with fp_cond) are built only when JUMPBRANCH_FPBR_EN is defined.
module jump_branch_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:31] instruction,
  input  logic [31:0] pc_plus_four,
  input  logic [31:0] rs1,
`ifdef JUMPBRANCH_FPBR_EN
  input  logic        fp_cond,
`endif
  output logic [31:0] outputPC,
  output logic        takeBranch,
  output logic [31:0] register31
);

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_BFPT = 6'h06;
  localparam logic [5:0] OP_BFPF = 6'h07;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  logic [5:0]  opcode;
  logic [31:0] imm16;
  logic [31:0] off26;
  logic        take;
  logic [31:0] target;
  logic        linkEn;
  logic [31:0] link_d;
  logic [31:0] link_q;

  assign opcode = instruction[0:5];
  assign imm16  = {{16{instruction[16]}}, instruction[16:31]};
  assign off26  = {{6{instruction[6]}}, instruction[6:31]};

  // Unknown or unlisted opcodes land in the default arm and never redirect.
  always_comb begin
    take   = 1'b0;
    target = pc_plus_four;
    linkEn = 1'b0;
    case (opcode)
      OP_J: begin
        take   = 1'b1;
        target = pc_plus_four + off26;
      end
      OP_JAL: begin
        take   = 1'b1;
        target = pc_plus_four + off26;
        linkEn = 1'b1;
      end
      OP_BEQZ: begin
        take   = (rs1 == 32'h0);
        target = pc_plus_four + imm16;
      end
      OP_BNEZ: begin
        take   = (rs1 != 32'h0);
        target = pc_plus_four + imm16;
      end
`ifdef JUMPBRANCH_FPBR_EN
      OP_BFPT: begin
        take   = fp_cond;
        target = pc_plus_four + imm16;
      end
      OP_BFPF: begin
        take   = ~fp_cond;
        target = pc_plus_four + imm16;
      end
`else
      OP_BFPT, OP_BFPF: begin
        take   = 1'b0;
        target = pc_plus_four;
      end
`endif
      OP_JR: begin
        take   = 1'b1;
        target = rs1;
      end
      OP_JALR: begin
        take   = 1'b1;
        target = rs1;
        linkEn = 1'b1;
      end
      default: begin
        take   = 1'b0;
        target = pc_plus_four;
      end
    endcase
  end

  // Reset suppresses any redirect combinationally, not just from the next edge.
  assign takeBranch = reset_n & take;
  assign outputPC   = takeBranch ? target : pc_plus_four;

  assign link_d = linkEn ? pc_plus_four : link_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) link_q <= 32'h0;
    else          link_q <= link_d;
  end

  assign register31 = link_q;

endmodule

// File: tb/tb_jump_branch_unit.sv
// Directed self-checking bench for jump_branch_unit using a queue-based scoreboard.
module tb_jump_branch_unit;

  typedef struct {
    string       tag;
    logic        take;
    logic [31:0] pc;
    logic [31:0] r31;
  } expect_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [31:0] rs1Val;
  logic        fpCond;
  logic [31:0] outputPC;
  logic        takeBranch;
  logic [31:0] register31;

  expect_t     scoreboard[$];
  logic [31:0] linkModel;
  int          total;
  int          bad;

  jump_branch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instruction  (instr),
    .pc_plus_four (pc4),
    .rs1          (rs1Val),
`ifdef JUMPBRANCH_FPBR_EN
    .fp_cond      (fpCond),
`endif
    .outputPC     (outputPC),
    .takeBranch   (takeBranch),
    .register31   (register31)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic checkOutput();
    expect_t e;
    if (scoreboard.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = scoreboard.pop_front();
    checkEq({e.tag, "_take"}, {31'h0, takeBranch}, {31'h0, e.take});
    checkEq({e.tag, "_pc"}, outputPC, e.pc);
    checkEq({e.tag, "_r31"}, register31, e.r31);
  endtask

  // Drives one instruction after a falling edge; the link model advances on the following rising edge.
  task automatic applyStimulus(input string tag, input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] r, input logic expTake, input logic [31:0] expPc);
    expect_t e;
    @(negedge clk);
    instr  = i;
    pc4    = p;
    rs1Val = r;
    e.tag  = tag;
    e.take = expTake;
    e.pc   = expPc;
    e.r31  = linkModel;
    scoreboard.push_back(e);
    #1;
    checkOutput();
    if (i[31:26] == 6'h03 || i[31:26] == 6'h13) linkModel = p;
  endtask

  initial begin
    logic fpTaken;
    total     = 0;
    bad       = 0;
    linkModel = 32'h0;
    fpCond    = 1'b0;
    reset_n   = 1'b0;
    instr     = 32'h0800_0010;
    pc4       = 32'h0000_0100;
    rs1Val    = 32'h0;

    // Reset holds even with a J on the bus.
    #12;
    checkEq("reset_take", {31'h0, takeBranch}, 32'h0);
    checkEq("reset_pc", outputPC, 32'h0000_0100);
    checkEq("reset_r31", register31, 32'h0);

    instr = 32'h0000_0020;
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus("j_fwd",     32'h0800_0010, 32'h0000_0100, 32'h0,  1'b1, 32'h0000_0110);
    applyStimulus("j_wrap",    32'h0BFF_FFF8, 32'h0000_0004, 32'h0,  1'b1, 32'hFFFF_FFFC);
    applyStimulus("beqz_take", 32'h1000_FFFC, 32'h0000_0200, 32'h0,  1'b1, 32'h0000_01FC);
    applyStimulus("beqz_not",  32'h1000_FFFC, 32'h0000_0200, 32'h5,  1'b0, 32'h0000_0200);
    applyStimulus("bnez_take", 32'h1400_0020, 32'h0000_0040, 32'h1,  1'b1, 32'h0000_0060);
    applyStimulus("bnez_not",  32'h1400_0020, 32'h0000_0040, 32'h0,  1'b0, 32'h0000_0040);
    applyStimulus("jal",       32'h0C00_0000, 32'h0000_0088, 32'h0,  1'b1, 32'h0000_0088);
    applyStimulus("add_hold",  32'h0000_0020, 32'h0000_008C, 32'h7,  1'b0, 32'h0000_008C);
    applyStimulus("jr_unalgn", 32'h4800_0000, 32'h0000_0090, 32'h0000_1233, 1'b1, 32'h0000_1233);
    applyStimulus("jalr_self", 32'h4C00_0000, 32'h0000_0094, 32'h0000_0088, 1'b1, 32'h0000_0088);

    // With fp_cond low, BFPT is never taken and BFPF is taken only when the FP option is built.
`ifdef JUMPBRANCH_FPBR_EN
    fpTaken = 1'b1;
`else
    fpTaken = 1'b0;
`endif
    applyStimulus("bfpt",      32'h1800_0010, 32'h0000_00A0, 32'h0, 1'b0, 32'h0000_00A0);
    applyStimulus("bfpf",      32'h1C00_0010, 32'h0000_00A0, 32'h0, fpTaken,
                  fpTaken ? 32'h0000_00B0 : 32'h0000_00A0);
    applyStimulus("rfe",       32'h4000_0000, 32'h0000_00C0, 32'h0, 1'b0, 32'h0000_00C0);
    applyStimulus("trap",      32'h4400_0004, 32'h0000_00C4, 32'h0, 1'b0, 32'h0000_00C4);
    applyStimulus("x_opcode",  32'hxxxx_xxxx, 32'h0000_00C8, 32'h0, 1'b0, 32'h0000_00C8);
    applyStimulus("jalr_rst",  32'h4C00_0000, 32'h0000_0050, 32'h0000_0300, 1'b1, 32'h0000_0300);

    @(posedge clk);
    #1;
    checkEq("jalr_link", register31, linkModel);

    // Asynchronous reset mid-cycle, away from either clock edge.
    #1;
    reset_n = 1'b0;
    linkModel = 32'h0;
    #1;
    checkEq("midrst_r31", register31, 32'h0);
    checkEq("midrst_take", {31'h0, takeBranch}, 32'h0);
    checkEq("midrst_pc", outputPC, 32'h0000_0050);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkEq("release_take", {31'h0, takeBranch}, 32'h1);
    checkEq("release_r31", register31, 32'h0);
    @(posedge clk);
    #1;
    checkEq("release_link", register31, 32'h0000_0050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
